fetch_prefetch_unit: RTL and testbench

- Parametrised successor to the single-register fetch stage of the pipelined core.
- Decouples instruction fetch from decode with a DEPTH-entry prefetch FIFO.
- Talks to instruction memory over a request/response handshake that tolerates variable latency and multiple outstanding requests.
- Handles execute-stage redirects by flushing the FIFO and discarding stale in-flight responses. Feeds InstrF/PCF/PCPlus4F to the F/D pipeline register.

---
 rtl/fetch_prefetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_prefetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// rtl/fetch_prefetch_unit.sv - prefetching instruction fetch stage with redirect flush
module fetch_prefetch_unit #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            StallD,
  input  logic            RedirectE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            IMemReq,
  output logic [XLEN-1:0] IMemAddr,
  input  logic            IMemReady,
  input  logic            IMemValid,
  input  logic [31:0]     IMemRData,
  output logic            ValidF,
  output logic [31:0]     InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] PCPlus4F
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [31:0]     fifo_instr [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   inflight_resp;
  logic [CW:0]     committed;
  logic            issue_ok;
  logic            issue_fire;
  logic            resp_valid;
  logic            push;
  logic            pop;
  logic            unused_tgt;

  // Handshake decode: issue only while buffered plus outstanding fetches leave room,
  // so a returning response can always be pushed without checking for full.
  always_comb begin
    committed     = {1'b0, count} + {1'b0, inflight};
    issue_ok      = !RedirectE && (committed < LIMIT);
    issue_fire    = RESET && issue_ok && IMemReady;
    resp_valid    = IMemValid && (inflight != '0);
    push          = resp_valid && (discard == '0) && !RedirectE;
    pop           = (count != '0) && !RedirectE && !StallD;
    inflight_resp = inflight - CW'(resp_valid);
    redirect_pc   = {PCTargetE[XLEN-1:2], 2'b00};
    unused_tgt    = ^PCTargetE[1:0];
  end

  // Outputs toward memory and decode; request is masked while reset is held.
  always_comb begin
    IMemReq  = RESET && issue_ok;
    IMemAddr = fetch_pc;
    ValidF   = (count != '0) && !RedirectE;
    InstrF   = fifo_instr[rd_ptr];
    PCF      = fifo_pc[rd_ptr];
    PCPlus4F = fifo_pc[rd_ptr] + XLEN'(4);
  end

  // Fetch/response PCs, FIFO pointers and request accounting; a redirect flushes
  // the FIFO and marks every still-unanswered request as stale.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
    end else if (RedirectE) begin
      fetch_pc <= redirect_pc;
      resp_pc  <= redirect_pc;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= inflight_resp;
      discard  <= inflight_resp;
    end else begin
      if (issue_fire) fetch_pc <= fetch_pc + XLEN'(4);
      inflight <= inflight_resp + CW'(issue_fire);
      if (resp_valid && (discard != '0)) discard <= discard - CW'(1);
      if (push) begin
        resp_pc <= resp_pc + XLEN'(4);
        wr_ptr  <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // FIFO storage; cleared on reset so the head reads RESET_PC and a zero word.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]    <= RESET_PC;
        fifo_instr[i] <= '0;
      end
    end else if (push) begin
      fifo_pc[wr_ptr]    <= resp_pc;
      fifo_instr[wr_ptr] <= IMemRData;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb/tb_fetch_prefetch_unit.sv - scoreboard bench for fetch_prefetch_unit
module tb_fetch_prefetch_unit;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0100;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } mreq_t;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        StallD = 1'b0;
  logic        RedirectE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady = 1'b0;
  logic        IMemValid = 1'b0;
  logic [31:0] IMemRData = '0;
  logic        ValidF;
  logic [31:0] InstrF;
  logic [31:0] PCF;
  logic [31:0] PCPlus4F;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rdy_rand = 1'b0;
  int          acc_cnt = 0;
  int          pop_cnt = 0;
  int          pop_base;
  int unsigned due_n;
  mreq_t       req_n;
  logic [31:0] exp_pc;
  logic [31:0] tgt;
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];

  fetch_prefetch_unit #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .CLK(CLK), .RESET(RESET), .StallD(StallD), .RedirectE(RedirectE),
    .PCTargetE(PCTargetE), .IMemReq(IMemReq), .IMemAddr(IMemAddr),
    .IMemReady(IMemReady), .IMemValid(IMemValid), .IMemRData(IMemRData),
    .ValidF(ValidF), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s actual=%s required=event", name, what);
  endtask

  task automatic seed(input logic [31:0] t);
    exp_q.delete();
    for (int i = 0; i < 16; i++) exp_q.push_back(t + 32'(4 * i));
  endtask

  task automatic top_up();
    while (exp_q.size() > 0 && exp_q.size() < 16) exp_q.push_back(exp_q[$] + 32'd4);
  endtask

  task automatic cycle();
    @(posedge CLK);
    #1;
    top_up();
  endtask

  task automatic at_neg();
    @(negedge CLK);
  endtask

  task automatic redirect(input logic [31:0] t);
    RedirectE = 1'b1;
    PCTargetE = t;
    seed({t[31:2], 2'b00});
    cycle();
    RedirectE = 1'b0;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] pc);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      at_neg();
      if (ValidF) seen = 1'b1;
      else cycle();
    end
    if (seen) check(name, PCF, pc);
    else fail_now(name, "timeout");
    cycle();
  endtask

  // Memory model: records accepted requests, retires the presented response, in order.
  always @(negedge CLK) begin
    if (RESET) begin
      if (IMemValid) void'(mem_q.pop_front());
      if (IMemReq && IMemReady) begin
        due_n = cyc + $urandom_range(lat_max, lat_min);
        if (mem_q.size() > 0 && due_n < mem_q[$].due) due_n = mem_q[$].due;
        req_n.addr = IMemAddr;
        req_n.due  = due_n;
        mem_q.push_back(req_n);
        acc_cnt++;
        check("outstanding_bound", 32'(mem_q.size() <= DEPTH), 32'd1);
      end
      if (RedirectE) begin
        check("req_in_redirect", 32'(IMemReq), 32'd0);
        check("valid_in_redirect", 32'(ValidF), 32'd0);
      end
    end
  end

  // Memory driver: presents the oldest due response and a (possibly random) ready.
  always @(posedge CLK) begin
    #1;
    IMemReady = rdy_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
    if (RESET && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      IMemValid = 1'b1;
      IMemRData = mem_word(mem_q[0].addr);
    end else begin
      IMemValid = 1'b0;
      IMemRData = $urandom;
    end
  end

  // Scoreboard monitor: every instruction handed to decode must be the next expected PC.
  always @(negedge CLK) begin
    if (RESET && ValidF && !StallD) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        fail_now("exp_underflow", "empty");
      end else begin
        exp_pc = exp_q.pop_front();
        check("pcf", PCF, exp_pc);
        check("instrf", InstrF, mem_word(exp_pc));
        check("pcplus4f", PCPlus4F, exp_pc + 32'd4);
      end
    end
  end

  initial begin
    seed(RPC);
    cycle();
    cycle();
    at_neg();
    check("rst_req", 32'(IMemReq), 32'd0);
    check("rst_addr", IMemAddr, RPC);
    check("rst_valid", 32'(ValidF), 32'd0);
    check("rst_instr", InstrF, 32'd0);
    check("rst_pcf", PCF, RPC);
    check("rst_pcplus4", PCPlus4F, RPC + 32'd4);

    // first-fetch latency and streaming
    cycle();
    RESET = 1'b1;
    at_neg();
    check("t1_req0", 32'(IMemReq), 32'd1);
    check("t1_addr0", IMemAddr, 32'h100);
    check("t1_valid0", 32'(ValidF), 32'd0);
    cycle();
    at_neg();
    check("t1_addr1", IMemAddr, 32'h104);
    check("t1_valid1", 32'(ValidF), 32'd0);
    cycle();
    at_neg();
    check("t1_valid2", 32'(ValidF), 32'd1);
    check("t1_pcf2", PCF, 32'h100);
    check("t1_pcplus4_2", PCPlus4F, 32'h104);
    check("t1_addr2", IMemAddr, 32'h108);
    for (int i = 0; i < 6; i++) begin
      cycle();
      at_neg();
      check("t1_stream", 32'(ValidF), 32'd1);
    end

    // stall fills the buffer to DEPTH
    cycle();
    StallD = 1'b1;
    redirect(32'h400);
    acc_cnt = 0;
    repeat (9) cycle();
    at_neg();
    check("t2_accepted", 32'(acc_cnt), 32'd4);
    check("t2_req_off", 32'(IMemReq), 32'd0);
    check("t2_valid", 32'(ValidF), 32'd1);
    check("t2_pcf", PCF, 32'h400);
    cycle();
    StallD = 1'b0;
    at_neg();
    check("t2_req_release", 32'(IMemReq), 32'd0);
    cycle();
    at_neg();
    check("t2_req_back", 32'(IMemReq), 32'd1);
    check("t2_addr_back", IMemAddr, 32'h410);
    repeat (8) cycle();

    // redirect coinciding with the only outstanding response
    check("t4_one_inflight", 32'(mem_q.size()), 32'd1);
    redirect(32'h300);
    at_neg();
    check("t4_req", 32'(IMemReq), 32'd1);
    check("t4_addr", IMemAddr, 32'h300);
    check("t4_flushed", 32'(ValidF), 32'd0);
    cycle();
    at_neg();
    check("t4_valid_r2", 32'(ValidF), 32'd0);
    cycle();
    at_neg();
    check("t4_valid_r3", 32'(ValidF), 32'd1);
    check("t4_pcf_r3", PCF, 32'h300);

    // target alignment and PC wrap
    cycle();
    redirect(32'h203);
    at_neg();
    check("t5_align", IMemAddr, 32'h200);
    cycle();
    redirect(32'hFFFF_FFF8);
    at_neg();
    check("t5_wrap0", IMemAddr, 32'hFFFF_FFF8);
    cycle();
    at_neg();
    check("t5_wrap1", IMemAddr, 32'hFFFF_FFFC);
    cycle();
    at_neg();
    check("t5_wrap2", IMemAddr, 32'h0000_0000);
    repeat (8) cycle();

    // redirect with stale responses in flight, 3-cycle memory
    lat_min = 3;
    lat_max = 3;
    repeat (10) cycle();
    for (int n = 0; n < 20 && mem_q.size() < 2; n++) cycle();
    check("t3_two_inflight", 32'(mem_q.size() >= 2), 32'd1);
    redirect(32'h200);
    at_neg();
    check("t3_flushed", 32'(ValidF), 32'd0);
    cycle();
    wait_valid("t3_first_pcf", 32'h200);
    repeat (10) cycle();

    // asynchronous reset with a partly filled buffer
    lat_min = 1;
    lat_max = 1;
    StallD = 1'b1;
    redirect(32'h500);
    repeat (5) cycle();
    at_neg();
    check("t6_pre_valid", 32'(ValidF), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    check("t6_async_valid", 32'(ValidF), 32'd0);
    check("t6_async_req", 32'(IMemReq), 32'd0);
    check("t6_async_addr", IMemAddr, RPC);
    check("t6_async_pcf", PCF, RPC);
    mem_q.delete();
    seed(RPC);
    StallD = 1'b0;
    cycle();
    RESET = 1'b1;
    at_neg();
    check("t6_resume_req", 32'(IMemReq), 32'd1);
    check("t6_resume_addr", IMemAddr, RPC);
    cycle();
    wait_valid("t6_resume_pcf", RPC);

    // randomized traffic: variable latency, ready, stalls and redirects
    lat_min = 1;
    lat_max = 4;
    rdy_rand = 1'b1;
    pop_base = pop_cnt;
    for (int i = 0; i < 1500; i++) begin
      StallD = ($urandom_range(9, 0) < 3);
      if ($urandom_range(24, 0) == 0) begin
        tgt = ($urandom_range(1, 0) == 0) ? $urandom : (32'hFFFF_FFF0 + 32'($urandom_range(15, 0)));
        redirect(tgt);
      end else begin
        cycle();
      end
    end
    StallD = 1'b0;
    repeat (20) cycle();
    check("random_progress", 32'((pop_cnt - pop_base) >= 150), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
